mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction-fetch requester (IF) and the load/store unit (LSU) of the rv32i core.
- Sits between the core and the memory top. The memory top has these properties:
  - It accepts one request per cycle.
  - It returns valid, with read data, exactly one cycle after the request.
- The arbiter does the following:
  - picks one requester per cycle;
  - drives the memory request;
  - tags the in-flight access;
  - routes the response back;
  - prevents IF starvation.

Parameters:
- DataWidth, 32, data bus width.
- Address, 8, memory word-address width.
- STARVE_LIMIT, 4, maximum consecutive LSU grants while IF is waiting; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held with if_addr until if_gnt.
- if_addr  input  Address  fetch address.
- if_gnt  output  1  fetch accepted this cycle (combinational).
- if_rvalid  output  1  fetch response valid.
- if_rdata  output  DataWidth  fetch data.
- flush  input  1  discard any in-flight fetch response (branch redirect).
- lsu_req  input  1  load/store request; held stable until lsu_gnt.
- lsu_we  input  1  1 = store, 0 = load.
- lsu_mask  input  4  byte-enable mask.
- lsu_addr  input  Address  data address.
- lsu_wdata  input  DataWidth  store data.
- lsu_gnt  output  1  LSU accepted this cycle (combinational).
- lsu_rvalid  output  1  LSU response valid; load data, or store acknowledge.
- lsu_rdata  output  DataWidth  load data; 0 for stores.
- mem_request  output  1  memory request.
- mem_we_re  output  1  memory write enable.
- mem_mask  output  4  memory byte mask.
- mem_address  output  Address  memory address.
- mem_data_in  output  DataWidth  memory write data.
- mem_valid  input  1  memory response valid.
- mem_data_out  input  DataWidth  memory read data.

Behaviour:
- Reset:
  - owner_q = NONE, streak_q = 0.
  - All gnt, rvalid and mem_* outputs are 0 while rst is low.
  - Reset mid-access drops the in-flight response; no rvalid follows.
- Grant (combinational, same cycle as the request):
  - Only one requester: it is granted.
  - Both requesting: LSU wins, unless streak_q == STARVE_LIMIT, in which case IF wins.
- Memory drive:
  - On a grant, mem_request = 1 and mem_* carry the winner's fields.
  - IF grants force mem_we_re = 0 and mem_mask = 4'hF.
  - No grant: mem_request = 0 and the other mem_* are 0.
- Tag register:
  - owner_q <= IF, LSU or NONE according to this cycle's grant.
  - owner_q <= FLUSHED_IF when the IF grant coincides with flush.
  - One request can be issued per cycle, fully pipelined with no bubbles.
- Streak counter:
  - Increments on an LSU grant while if_req = 1.
  - Resets to 0 on any IF grant, or on any cycle with if_req = 0.
  - Saturates at STARVE_LIMIT.
- Response (latency 1 cycle after grant), on mem_valid:
  - owner_q == IF and flush = 0: if_rvalid = 1, if_rdata = mem_data_out.
  - owner_q == LSU: lsu_rvalid = 1.
  - LSU load: lsu_rdata = mem_data_out. LSU store: lsu_rdata = 0. A store-flag register records which.
- Inactive response outputs: rdata = 0 whenever the corresponding rvalid = 0.
- Flush:
  - flush in the response cycle of an IF access suppresses if_rvalid.
  - flush in the grant cycle marks the access FLUSHED_IF, so its response is also suppressed.
  - flush never affects LSU.
- Stray response: mem_valid with owner_q NONE or FLUSHED_IF is ignored.
- Simultaneous grant and response: allowed. Response routing uses owner_q; the new grant updates owner_q for the next cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Priority alternates; the last-granted requester has lower priority on the next conflict.
  - STARVE_LIMIT and streak_q are unused.
  - last_q resets to IF, so LSU wins the first conflict.
- Undefined: LSU-priority scheme with the starvation limit, as described in Behaviour.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_IF, OWN_LSU, OWN_FLUSHED_IF};
  - localparam MASK_FULL = 4'hF.
- Sub-module mem_arb_priority contains the grant logic plus the streak/last register. It outputs gnt_if and gnt_lsu.
- The top module holds owner_q and the mux/route logic.

Test Plan:
- IF alone: if_req=1, if_addr=8'h10 for 3 cycles.
  - Expect if_gnt=1 each cycle, mem_address 10, mem_we_re=0, mem_mask=F.
  - Expect if_rvalid=1 on cycles 2–4 with data mem[10].
- LSU store then load: store mask=4'b0011, addr=8'h20, wdata=32'hDEADBEEF, then a load from 20.
  - Store: lsu_rvalid=1 with lsu_rdata=0.
  - Load: lsu_rdata=32'h0000BEEF, assuming the memory was pre-zeroed.
- Conflict/starvation, both requesting continuously, STARVE_LIMIT=4:
  - Default build: grant pattern L,L,L,L,I,L,L,L,L,I.
  - ARB_ROUND_ROBIN_EN build: L,I,L,I.
- Flush: IF granted at cycle t, flush=1 at t+1.
  - if_rvalid stays 0 at t+1.
  - An LSU grant at t+1 still responds at t+2.
- Reset mid-access: LSU load granted, rst low on the next edge.
  - All outputs 0 and no lsu_rvalid.
  - After release, an IF request is granted normally.
- Back-to-back alternating: IF@A0, LSU@B0, IF@A1 on consecutive cycles.
  - Responses route to the correct port in order, with no lost or duplicated rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter: access-owner tag and constants.
// Optional build macro ARB_ROUND_ROBIN_EN selects alternating priority (see mem_arb_priority).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU,
        OWN_FLUSHED_IF
    } owner_e;

    localparam logic [3:0] MASK_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signals of the arbiter.
// Handshake: a requester holds req and its fields stable until the same-cycle gnt; rvalid arrives one cycle after gnt.
interface mem_port_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int Address   = 8
);
    logic                 if_req;
    logic [Address-1:0]   if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic [DataWidth-1:0] if_rdata;
    logic                 flush;

    logic                 lsu_req;
    logic                 lsu_we;
    logic [3:0]           lsu_mask;
    logic [Address-1:0]   lsu_addr;
    logic [DataWidth-1:0] lsu_wdata;
    logic                 lsu_gnt;
    logic                 lsu_rvalid;
    logic [DataWidth-1:0] lsu_rdata;

    logic                 mem_request;
    logic                 mem_we_re;
    logic [3:0]           mem_mask;
    logic [Address-1:0]   mem_address;
    logic [DataWidth-1:0] mem_data_in;
    logic                 mem_valid;
    logic [DataWidth-1:0] mem_data_out;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, flush,
        input  lsu_req, lsu_we, lsu_mask, lsu_addr, lsu_wdata,
        input  mem_valid, mem_data_out,
        output if_gnt, if_rvalid, if_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in
    );

    // Core plus memory view.
    modport master (
        output if_req, if_addr, flush,
        output lsu_req, lsu_we, lsu_mask, lsu_addr, lsu_wdata,
        output mem_valid, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in
    );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Grant selection between IF and LSU. Default: LSU priority bounded by STARVE_LIMIT.
// With ARB_ROUND_ROBIN_EN defined, priority alternates away from the last-granted requester.
module mem_arb_priority #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic lsu_req,
    output logic gnt_if,
    output logic gnt_lsu
);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        gnt_if     = rst && if_req && (!lsu_req || last_lsu_q);
        gnt_lsu    = rst && lsu_req && !gnt_if;
        last_lsu_d = last_lsu_q;
        if (gnt_lsu) begin
            last_lsu_d = 1'b1;
        end else if (gnt_if) begin
            last_lsu_d = 1'b0;
        end
    end

    // Reset as if IF was granted last, so LSU takes the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_lsu_q <= 1'b0;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak_q, streak_d;

    always_comb begin
        gnt_if   = rst && if_req && (!lsu_req || (streak_q == LIMIT));
        gnt_lsu  = rst && lsu_req && !gnt_if;
        streak_d = streak_q;
        // streak_q counts LSU wins while IF is left waiting.
        if (!if_req || gnt_if) begin
            streak_d = 4'd0;
        end else if (gnt_lsu && (streak_q != LIMIT)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU; tags each access and routes its response.
// Build option ARB_ROUND_ROBIN_EN (in mem_arb_priority) swaps the starvation-limited scheme for alternation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int Address      = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output owner_e              dbg_owner
);

    logic                 gnt_if, gnt_lsu;
    owner_e               owner_q, owner_d;
    logic                 store_q, store_d;

    logic                 mem_request_c, mem_we_re_c;
    logic [3:0]           mem_mask_c;
    logic [Address-1:0]   mem_address_c;
    logic [DataWidth-1:0] mem_data_in_c;
    logic                 if_rvalid_c, lsu_rvalid_c;
    logic [DataWidth-1:0] if_rdata_c, lsu_rdata_c;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clk     (clk),
        .rst     (rst),
        .if_req  (bus.if_req),
        .lsu_req (bus.lsu_req),
        .gnt_if  (gnt_if),
        .gnt_lsu (gnt_lsu)
    );

    always_comb begin
        mem_request_c = gnt_if | gnt_lsu;
        mem_we_re_c   = 1'b0;
        mem_mask_c    = 4'h0;
        mem_address_c = '0;
        mem_data_in_c = '0;
        if (gnt_if) begin
            mem_mask_c    = MASK_FULL;
            mem_address_c = bus.if_addr;
        end else if (gnt_lsu) begin
            mem_we_re_c   = bus.lsu_we;
            mem_mask_c    = bus.lsu_mask;
            mem_address_c = bus.lsu_addr;
            mem_data_in_c = bus.lsu_wdata;
        end
    end

    // A fetch granted during a flush is already stale; its response must be dropped.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt_if) begin
            owner_d = bus.flush ? OWN_FLUSHED_IF : OWN_IF;
        end else if (gnt_lsu) begin
            owner_d = OWN_LSU;
        end
        store_d = gnt_lsu & bus.lsu_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        if_rvalid_c  = rst && bus.mem_valid && (owner_q == OWN_IF) && !bus.flush;
        lsu_rvalid_c = rst && bus.mem_valid && (owner_q == OWN_LSU);
        if_rdata_c   = if_rvalid_c ? bus.mem_data_out : '0;
        lsu_rdata_c  = (lsu_rvalid_c && !store_q) ? bus.mem_data_out : '0;
    end

    assign bus.if_gnt      = gnt_if;
    assign bus.lsu_gnt     = gnt_lsu;
    assign bus.mem_request = mem_request_c;
    assign bus.mem_we_re   = mem_we_re_c;
    assign bus.mem_mask    = mem_mask_c;
    assign bus.mem_address = mem_address_c;
    assign bus.mem_data_in = mem_data_in_c;
    assign bus.if_rvalid   = if_rvalid_c;
    assign bus.if_rdata    = if_rdata_c;
    assign bus.lsu_rvalid  = lsu_rvalid_c;
    assign bus.lsu_rdata   = lsu_rdata_c;
    assign dbg_owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: emulated one-cycle memory, arbitration reference model, response scoreboard.
// Honours ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  owner_e dbg_owner;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DataWidth(DW), .Address(AW)) bus ();

  mem_port_arbiter #(
    .DataWidth    (DW),
    .Address      (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_owner (dbg_owner)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_lsu_q[$];

  logic [DW-1:0] mem [256];
  bit            pend_v;
  logic [DW-1:0] pend_d;
  bit            pend_if;
  int            lsu_run;
  bit            last_lsu;
  bit            got_if, got_lsu, dut_gi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_if_q.delete();
    exp_lsu_q.delete();
    pend_v   = 1'b0;
    pend_d   = '0;
    pend_if  = 1'b0;
    lsu_run  = 0;
    last_lsu = 1'b0;
  endtask

  task automatic set_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.flush     = 1'b0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_mask  = 4'h0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit ireq, input logic [7:0] iaddr, input bit fl,
                             input bit lreq, input bit lwe, input logic [3:0] lmask,
                             input logic [7:0] laddr, input logic [31:0] lwd);
    bit gi, gl;
    logic [44:0] exp_fields;
    @(negedge clk);
    bus.mem_valid    = pend_v;
    bus.mem_data_out = pend_d;
    // A flush in the response cycle cancels the fetch issued last cycle.
    if (fl && pend_if) void'(exp_if_q.pop_back());
    bus.if_req    = ireq;
    bus.if_addr   = iaddr;
    bus.flush     = fl;
    bus.lsu_req   = lreq;
    bus.lsu_we    = lwe;
    bus.lsu_mask  = lmask;
    bus.lsu_addr  = laddr;
    bus.lsu_wdata = lwd;
    #1;
    // Reference arbitration from the stated rules.
    gi = ireq;
    if (ireq && lreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      gi = last_lsu;
`else
      gi = (lsu_run >= LIMIT);
`endif
    end
    gl = lreq && !gi;
    check("if_gnt", bus.if_gnt, gi);
    check("lsu_gnt", bus.lsu_gnt, gl);
    check("mem_request", bus.mem_request, gi | gl);
    if (gi)      exp_fields = {1'b0, MASK_FULL, iaddr, 32'h0};
    else if (gl) exp_fields = {lwe, lmask, laddr, lwd};
    else         exp_fields = '0;
    check("mem_fields", {bus.mem_we_re, bus.mem_mask, bus.mem_address, bus.mem_data_in}, exp_fields);
    if (gi && !fl) exp_if_q.push_back(mem[iaddr]);
    if (gl) exp_lsu_q.push_back(lwe ? 32'h0 : mem[laddr]);
    pend_if = gi && !fl;
`ifdef ARB_ROUND_ROBIN_EN
    if (gl) last_lsu = 1'b1;
    else if (gi) last_lsu = 1'b0;
`else
    if (!ireq || gi) lsu_run = 0;
    else if (gl && lsu_run < LIMIT) lsu_run++;
`endif
    // Emulated memory: answers next cycle with pre-write contents, applies masked writes.
    pend_v = bus.mem_request;
    pend_d = mem[bus.mem_address];
    if (bus.mem_request && bus.mem_we_re)
      for (int b = 0; b < 4; b++)
        if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] = bus.mem_data_in[8*b +: 8];
    got_if  = gi;
    got_lsu = gl;
    dut_gi  = bus.if_gnt;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 8'h0, 0, 0, 0, 4'h0, 8'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.if_gnt, bus.lsu_gnt, bus.if_rvalid, bus.lsu_rvalid, bus.if_rdata, bus.lsu_rdata,
                 bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_address} != '0, 1'b0);
    check({name, "_data_in"}, bus.mem_data_in, 32'h0);
    check({name, "_owner"}, dbg_owner, OWN_NONE);
  endtask

  // Reset asserted at the next negedge with both requesters active; response of the prior grant is lost.
  task automatic reset_mid_access();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_valid    = pend_v;
    bus.mem_data_out = pend_d;
    bus.if_req  = 1'b1;
    bus.lsu_req = 1'b1;
    #1;
    check_all_zero("reset_mid");
    model_reset();
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(negedge clk);
    set_idle();
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (bus.if_rvalid) begin
      if (exp_if_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_rvalid_unexpected: got 1 expected 0 (rdata %0h)", bus.if_rdata);
      end else begin
        check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
      end
    end else begin
      check("if_rdata_idle", bus.if_rdata, 32'h0);
    end
    if (bus.lsu_rvalid) begin
      if (exp_lsu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lsu_rvalid_unexpected: got 1 expected 0 (rdata %0h)", bus.lsu_rdata);
      end else begin
        check("lsu_rdata", bus.lsu_rdata, exp_lsu_q.pop_front());
      end
    end else begin
      check("lsu_rdata_idle", bus.lsu_rdata, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] pat;
  logic [9:0] exp_pat;
  bit         ir, lr, lw, fl;
  logic [7:0] ia, la;
  logic [3:0] lm;
  logic [31:0] ld;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i >= 32 && i < 48) ? 32'h0 : $urandom;
    rst = 1'b0;
    set_idle();
    bus.mem_valid    = 1'b0;
    bus.mem_data_out = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    // IF alone, same address for three cycles.
    repeat (3) drive_cycle(1, 8'h10, 0, 0, 0, 4'h0, 8'h0, 32'h0);
    idle_cycle();

    // Continuous conflict.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 8'h44, 0, 1, 0, 4'hF, 8'h31, 32'h0);
      pat[i] = dut_gi;
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_pat = 10'b1010101010;
`else
    exp_pat = 10'b1000010000;
`endif
    check("grant_pattern", pat, exp_pat);
    idle_cycle();

    // Partial store then load from pre-zeroed word.
    drive_cycle(0, 8'h0, 0, 1, 1, 4'b0011, 8'h20, 32'hDEADBEEF);
    drive_cycle(0, 8'h0, 0, 1, 0, 4'hF, 8'h20, 32'h0);
    idle_cycle();
    check("load_after_store", {bus.lsu_rvalid, bus.lsu_rdata}, {1'b1, 32'h0000BEEF});

    // Flush in the response cycle, with an LSU grant alongside.
    drive_cycle(1, 8'h11, 0, 0, 0, 4'h0, 8'h0, 32'h0);
    drive_cycle(0, 8'h0, 1, 1, 0, 4'hF, 8'h21, 32'h0);
    check("flush_resp_if_rvalid", bus.if_rvalid, 1'b0);
    idle_cycle();
    check("lsu_after_flush", bus.lsu_rvalid, 1'b1);

    // Flush in the grant cycle.
    drive_cycle(1, 8'h12, 1, 0, 0, 4'h0, 8'h0, 32'h0);
    idle_cycle();
    check("flush_grant_if_rvalid", bus.if_rvalid, 1'b0);

    // Reset mid-access, then normal fetch.
    drive_cycle(0, 8'h0, 0, 1, 0, 4'hF, 8'h22, 32'h0);
    reset_mid_access();
    drive_cycle(1, 8'h13, 0, 0, 0, 4'h0, 8'h0, 32'h0);
    idle_cycle();
    check("if_after_reset", bus.if_rvalid, 1'b1);

    // Back-to-back alternating owners.
    drive_cycle(1, 8'h50, 0, 0, 0, 4'h0, 8'h0, 32'h0);
    drive_cycle(0, 8'h0, 0, 1, 0, 4'hF, 8'h60, 32'h0);
    drive_cycle(1, 8'h51, 0, 0, 0, 4'h0, 8'h0, 32'h0);
    idle_cycle();
    idle_cycle();

    // Randomized traffic with held requests.
    ir = 0; lr = 0; ia = '0; la = '0; lw = 0; lm = '0; ld = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ir) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = 8'($urandom);
      end
      if (!lr) begin
        lr = ($urandom_range(0, 2) != 0);
        la = 8'($urandom);
        lw = $urandom_range(0, 1);
        lm = 4'($urandom);
        ld = $urandom;
      end
      fl = ($urandom_range(0, 5) == 0);
      drive_cycle(ir, ia, fl, lr, lw, lm, la, ld);
      if (got_if) ir = 0;
      if (got_lsu) lr = 0;
    end
    idle_cycle();
    idle_cycle();
    check("if_queue_drained", exp_if_q.size(), 0);
    check("lsu_queue_drained", exp_lsu_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
